// File: rtl/sd_slv_pkg.sv
// Shared encodings for the SD slave card state machine: card states,
// response types, command indices and card-status bit positions.
package sd_slv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_IDENT = 4'd2,
    ST_STBY  = 4'd3,
    ST_TRAN  = 4'd4,
    ST_DATA  = 4'd5,
    ST_RCV   = 4'd6,
    ST_PRG   = 4'd7,
    ST_DIS   = 4'd8,
    ST_INA   = 4'd15
  } sd_state_e;

  typedef enum logic [2:0] {
    RSP_NONE = 3'd0,
    RSP_R1   = 3'd1,
    RSP_R1B  = 3'd2,
    RSP_R2   = 3'd3,
    RSP_R3   = 3'd4,
    RSP_R6   = 3'd6,
    RSP_R7   = 3'd7
  } sd_rsp_e;

  // Command indices (ACMDs share the index space, qualified by app_cmd)
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] ACMD6  = 6'd6;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD9   = 6'd9;
  localparam logic [5:0] CMD10  = 6'd10;
  localparam logic [5:0] CMD12  = 6'd12;
  localparam logic [5:0] CMD13  = 6'd13;
  localparam logic [5:0] CMD15  = 6'd15;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD18  = 6'd18;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD25  = 6'd25;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;

  // R1 card-status bit positions
  localparam int CS_BLKLEN_ERR = 29;
  localparam int CS_ILLEGAL    = 22;
  localparam int CS_STATE_LSB  = 9;
  localparam int CS_RDY_DATA   = 8;
  localparam int CS_APP_CMD    = 5;

  // True for responses whose completion clears the sticky error bits
  function automatic logic is_r1_class(input logic [2:0] rsp);
    return (rsp == RSP_R1) || (rsp == RSP_R1B);
  endfunction

endpackage

// File: rtl/sd_slv_cmd_dec.sv
// Combinational command table: given the current card state, the command
// index, app_cmd and RCA match, decide legality, response type and the
// requested next state. Argument-dependent details (CMD16 range, ACMD41
// busy polling) are resolved by the caller.
module sd_slv_cmd_dec
  import sd_slv_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_idx,
  input  logic       i_app_cmd,
  input  logic       i_match,
  output logic       o_legal,
  output logic [2:0] o_rsp_type,
  output logic [3:0] o_nxt_state
);

  sd_state_e w_state;
  assign w_state = sd_state_e'(i_state);

  // Per-state legality / response / next-state lookup
  always_comb begin
    o_legal     = 1'b0;
    o_rsp_type  = RSP_NONE;
    o_nxt_state = i_state;
    if (w_state != ST_INA) begin
      if (i_idx == CMD0) begin
        o_legal     = 1'b1;
        o_nxt_state = ST_IDLE;
      end else if (i_idx == CMD55) begin
        // Before an RCA exists the card answers CMD55 unconditionally
        if (w_state == ST_IDLE || i_match) begin
          o_legal    = 1'b1;
          o_rsp_type = RSP_R1;
        end
      end else begin
        case (w_state)
          ST_IDLE: begin
            if (i_idx == CMD8) begin
              o_legal = 1'b1; o_rsp_type = RSP_R7;
            end else if (i_idx == ACMD41 && i_app_cmd) begin
              o_legal = 1'b1; o_rsp_type = RSP_R3; o_nxt_state = ST_READY;
            end
          end
          ST_READY: begin
            if (i_idx == CMD2) begin
              o_legal = 1'b1; o_rsp_type = RSP_R2; o_nxt_state = ST_IDENT;
            end
          end
          ST_IDENT: begin
            if (i_idx == CMD3) begin
              o_legal = 1'b1; o_rsp_type = RSP_R6; o_nxt_state = ST_STBY;
            end
          end
          ST_STBY: begin
            case (i_idx)
              CMD3: begin o_legal = 1'b1; o_rsp_type = RSP_R6; end
              CMD9, CMD10: if (i_match) begin o_legal = 1'b1; o_rsp_type = RSP_R2; end
              CMD7: if (i_match) begin
                o_legal = 1'b1; o_rsp_type = RSP_R1B; o_nxt_state = ST_TRAN;
              end
              CMD13: if (i_match) begin o_legal = 1'b1; o_rsp_type = RSP_R1; end
              CMD15: if (i_match) begin o_legal = 1'b1; o_nxt_state = ST_INA; end
              default: ;
            endcase
          end
          ST_TRAN: begin
            case (i_idx)
              CMD13, CMD16: begin o_legal = 1'b1; o_rsp_type = RSP_R1; end
              CMD17, CMD18: begin
                o_legal = 1'b1; o_rsp_type = RSP_R1; o_nxt_state = ST_DATA;
              end
              CMD24, CMD25: begin
                o_legal = 1'b1; o_rsp_type = RSP_R1; o_nxt_state = ST_RCV;
              end
              ACMD6: if (i_app_cmd) begin o_legal = 1'b1; o_rsp_type = RSP_R1; end
              CMD7: if (!i_match) begin o_legal = 1'b1; o_nxt_state = ST_STBY; end
              default: ;
            endcase
          end
          ST_DATA: begin
            if (i_idx == CMD12) begin
              o_legal = 1'b1; o_rsp_type = RSP_R1B; o_nxt_state = ST_TRAN;
            end else if (i_idx == CMD7 && !i_match) begin
              o_legal = 1'b1; o_nxt_state = ST_STBY;
            end
          end
          ST_RCV: begin
            if (i_idx == CMD12) begin
              o_legal = 1'b1; o_rsp_type = RSP_R1B; o_nxt_state = ST_PRG;
            end
          end
          ST_PRG: begin
            if (i_idx == CMD7 && !i_match) begin
              o_legal = 1'b1; o_nxt_state = ST_DIS;
            end else if (i_idx == CMD13) begin
              o_legal = 1'b1; o_rsp_type = RSP_R1;
            end
          end
          ST_DIS: begin
            if (i_idx == CMD7 && i_match) begin
              o_legal = 1'b1; o_nxt_state = ST_PRG;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sd_slv_card_fsm.sv
// SD slave card state machine. Evaluates each parsed command against the
// current state, tracks RCA / app_cmd / block length / bus width, and
// drives response type, R1 card status, data-path start strobes and the
// DAT0 busy indication for prg/dis.
module sd_slv_card_fsm
  import sd_slv_pkg::*;
#(
  parameter logic [15:0] RCA_DFLT       = 16'h0001,
  parameter int          OCR_BUSY_POLLS = 2,
  parameter int          PRG_CYCLES     = 64,
  parameter int          BLK_LEN_W      = 12,
  parameter int          MAX_BLK_LEN    = 512
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  input  logic [5:0]           cmd_idx,
  input  logic [31:0]          cmd_arg,
  input  logic                 rsp_end,
  input  logic                 rd_done,
  input  logic                 wr_done,
  output logic [3:0]           cur_state,
  output logic [15:0]          rca,
  output logic [2:0]           rsp_type,
  output logic                 rsp_long,
  output logic [31:0]          card_status,
  output logic                 ocr_rdy,
  output logic [BLK_LEN_W-1:0] blk_len,
  output logic                 rd_start,
  output logic                 wr_start,
  output logic                 multi,
  output logic                 bus_w4,
  output logic                 busy,
  output logic                 illegal_cmd
);

  localparam int POLL_W = $clog2(OCR_BUSY_POLLS + 2);
  localparam int BCNT_W = $clog2(PRG_CYCLES + 1);
  localparam logic [BLK_LEN_W-1:0] BLK_DFLT = BLK_LEN_W'(512);

  sd_state_e            r_state, w_state_nxt, w_evt_state;
  logic [15:0]          r_rca, w_rca_nxt;
  logic [2:0]           r_rsp, w_rsp_nxt;
  logic                 r_rsp_long;
  logic                 r_ocr, w_ocr_nxt;
  logic [BLK_LEN_W-1:0] r_blk, w_blk_nxt;
  logic                 r_rd_st, w_rd_st_nxt;
  logic                 r_wr_st, w_wr_st_nxt;
  logic                 r_multi, w_multi_nxt;
  logic                 r_bw4, w_bw4_nxt;
  logic                 r_ill, w_ill_nxt;
  logic                 r_app, w_app_nxt;
  logic                 r_st_ill, w_st_ill_nxt;
  logic                 r_st_blk, w_st_blk_nxt;
  logic [POLL_W-1:0]    r_poll, w_poll_nxt;
  logic [BCNT_W-1:0]    r_bcnt, w_bcnt_nxt;

  logic       w_match, w_legal, w_evt, w_cmd_chg, w_bexp, w_in_busy, w_nxt_busy;
  logic [2:0] w_dec_rsp;
  logic [3:0] w_dec_nxt;

  assign w_match   = (cmd_arg[31:16] == r_rca);
  assign w_in_busy = (r_state == ST_PRG) || (r_state == ST_DIS);
  assign w_bexp    = w_in_busy && (r_bcnt == BCNT_W'(PRG_CYCLES - 1));

  sd_slv_cmd_dec u_dec (
    .i_state     (r_state),
    .i_idx       (cmd_idx),
    .i_app_cmd   (r_app),
    .i_match     (w_match),
    .o_legal     (w_legal),
    .o_rsp_type  (w_dec_rsp),
    .o_nxt_state (w_dec_nxt)
  );

  // Next-state and output decode: command first, then data/busy events
  always_comb begin
    w_state_nxt  = r_state;
    w_rca_nxt    = r_rca;
    w_rsp_nxt    = rsp_end ? 3'(RSP_NONE) : r_rsp;
    w_ocr_nxt    = r_ocr;
    w_blk_nxt    = r_blk;
    w_rd_st_nxt  = 1'b0;
    w_wr_st_nxt  = 1'b0;
    w_multi_nxt  = r_multi;
    w_bw4_nxt    = r_bw4;
    w_ill_nxt    = 1'b0;
    w_app_nxt    = r_app;
    w_st_ill_nxt = r_st_ill;
    w_st_blk_nxt = r_st_blk;
    w_poll_nxt   = r_poll;
    w_bcnt_nxt   = '0;
    w_evt        = 1'b0;
    w_evt_state  = r_state;
    w_cmd_chg    = 1'b0;
    w_nxt_busy   = 1'b0;

    // Sticky errors are reported once, then cleared as that R1 completes
    if (rsp_end && is_r1_class(r_rsp)) begin
      w_st_ill_nxt = 1'b0;
      w_st_blk_nxt = 1'b0;
    end

    // Data-path / busy-timer events that move the state on their own
    case (r_state)
      ST_DATA: if (rd_done && !r_multi) begin w_evt = 1'b1; w_evt_state = ST_TRAN; end
      ST_RCV:  if (wr_done) begin w_evt = 1'b1; w_evt_state = ST_PRG; end
      ST_PRG:  if (w_bexp)  begin w_evt = 1'b1; w_evt_state = ST_TRAN; end
      ST_DIS:  if (w_bexp)  begin w_evt = 1'b1; w_evt_state = ST_STBY; end
      default: ;
    endcase

    // ina swallows every command silently
    if (cmd_vld && r_state != ST_INA) begin
      w_app_nxt = 1'b0;
      if (w_legal) begin
        w_rsp_nxt   = w_dec_rsp;
        w_state_nxt = sd_state_e'(w_dec_nxt);
        case (cmd_idx)
          CMD0: begin
            w_rca_nxt  = '0;
            w_bw4_nxt  = 1'b0;
            w_ocr_nxt  = 1'b0;
            w_poll_nxt = '0;
            w_blk_nxt  = BLK_DFLT;
          end
          CMD55: w_app_nxt = 1'b1;
          ACMD41: begin
            if (r_poll < POLL_W'(OCR_BUSY_POLLS)) begin
              w_ocr_nxt   = 1'b0;
              w_poll_nxt  = r_poll + 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_ocr_nxt = 1'b1;
            end
          end
          CMD3: if (r_state == ST_IDENT) w_rca_nxt = RCA_DFLT;
          CMD16: begin
            if (cmd_arg != 32'd0 && cmd_arg <= 32'(MAX_BLK_LEN))
              w_blk_nxt = cmd_arg[BLK_LEN_W-1:0];
            else
              w_st_blk_nxt = 1'b1;
          end
          CMD17, CMD18: begin
            w_rd_st_nxt = 1'b1;
            w_multi_nxt = (cmd_idx == CMD18);
          end
          CMD24, CMD25: begin
            w_wr_st_nxt = 1'b1;
            w_multi_nxt = (cmd_idx == CMD25);
          end
          ACMD6: w_bw4_nxt = (cmd_arg[1:0] == 2'b10);
          default: ;
        endcase
      end else begin
        w_rsp_nxt    = RSP_NONE;
        w_ill_nxt    = 1'b1;
        w_st_ill_nxt = 1'b1;
      end
      w_cmd_chg = (w_state_nxt != r_state);
    end

    // A command that moved the state wins; otherwise the event still lands
    if (w_evt && !w_cmd_chg) w_state_nxt = w_evt_state;

    // Busy timer keeps running across prg<->dis, restarts after expiry
    w_nxt_busy = (w_state_nxt == ST_PRG) || (w_state_nxt == ST_DIS);
    if (w_nxt_busy && w_in_busy && !w_bexp) w_bcnt_nxt = r_bcnt + 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rca      <= '0;
      r_rsp      <= RSP_NONE;
      r_rsp_long <= 1'b0;
      r_ocr      <= 1'b0;
      r_blk      <= BLK_DFLT;
      r_rd_st    <= 1'b0;
      r_wr_st    <= 1'b0;
      r_multi    <= 1'b0;
      r_bw4      <= 1'b0;
      r_ill      <= 1'b0;
      r_app      <= 1'b0;
      r_st_ill   <= 1'b0;
      r_st_blk   <= 1'b0;
      r_poll     <= '0;
      r_bcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rca      <= w_rca_nxt;
      r_rsp      <= w_rsp_nxt;
      r_rsp_long <= (w_rsp_nxt == RSP_R2);
      r_ocr      <= w_ocr_nxt;
      r_blk      <= w_blk_nxt;
      r_rd_st    <= w_rd_st_nxt;
      r_wr_st    <= w_wr_st_nxt;
      r_multi    <= w_multi_nxt;
      r_bw4      <= w_bw4_nxt;
      r_ill      <= w_ill_nxt;
      r_app      <= w_app_nxt;
      r_st_ill   <= w_st_ill_nxt;
      r_st_blk   <= w_st_blk_nxt;
      r_poll     <= w_poll_nxt;
      r_bcnt     <= w_bcnt_nxt;
    end
  end

  // R1 card-status word assembled from live state
  always_comb begin
    card_status                           = '0;
    card_status[CS_BLKLEN_ERR]            = r_st_blk;
    card_status[CS_ILLEGAL]               = r_st_ill;
    card_status[CS_STATE_LSB+3:CS_STATE_LSB] = r_state;
    card_status[CS_RDY_DATA]              = (r_state == ST_TRAN);
    card_status[CS_APP_CMD]               = r_app;
  end

  assign cur_state   = r_state;
  assign rca         = r_rca;
  assign rsp_type    = r_rsp;
  assign rsp_long    = r_rsp_long;
  assign ocr_rdy     = r_ocr;
  assign blk_len     = r_blk;
  assign rd_start    = r_rd_st;
  assign wr_start    = r_wr_st;
  assign multi       = r_multi;
  assign bus_w4      = r_bw4;
  assign busy        = w_in_busy;
  assign illegal_cmd = r_ill;

endmodule

// File: tb/tb_sd_slv_card_fsm.sv
// Directed bench for the SD slave card state machine. Inputs change on the
// falling edge; outputs are sampled on the following falling edge.
module tb_sd_slv_card_fsm;

  logic        clk = 1'b0;
  logic        rst, cmd_vld, rsp_end, rd_done, wr_done;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [3:0]  cur_state;
  logic [15:0] rca;
  logic [2:0]  rsp_type;
  logic        rsp_long, ocr_rdy, rd_start, wr_start, multi, bus_w4, busy, illegal_cmd;
  logic [31:0] card_status;
  logic [11:0] blk_len;

  int n_tests = 0;
  int n_fail  = 0;

  sd_slv_card_fsm #(
    .RCA_DFLT(16'h0001), .OCR_BUSY_POLLS(2), .PRG_CYCLES(64),
    .BLK_LEN_W(12), .MAX_BLK_LEN(512)
  ) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .rsp_end(rsp_end), .rd_done(rd_done), .wr_done(wr_done),
    .cur_state(cur_state), .rca(rca), .rsp_type(rsp_type), .rsp_long(rsp_long),
    .card_status(card_status), .ocr_rdy(ocr_rdy), .blk_len(blk_len),
    .rd_start(rd_start), .wr_start(wr_start), .multi(multi), .bus_w4(bus_w4),
    .busy(busy), .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clk); cmd_vld = 1'b1; cmd_idx = idx; cmd_arg = arg;
    @(negedge clk); cmd_vld = 1'b0; cmd_idx = '0; cmd_arg = '0;
  endtask

  task automatic do_rsp_end;
    @(negedge clk); rsp_end = 1'b1;
    @(negedge clk); rsp_end = 1'b0;
  endtask

  task automatic bring_to_stby;
    for (int i = 0; i < 3; i++) begin
      cmd(6'd55, 32'h0);
      cmd(6'd41, 32'h40FF_8000);
    end
    cmd(6'd2, 32'h0);
    cmd(6'd3, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_vld = 0; cmd_idx = 0; cmd_arg = 0; rsp_end = 0; rd_done = 0; wr_done = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (cur_state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", cur_state); end
    n_tests++; if (rca !== 16'h0) begin n_fail++; $display("FAIL reset_rca got %h exp 0", rca); end
    n_tests++; if ({rsp_type, rsp_long, ocr_rdy} !== 5'b0) begin n_fail++; $display("FAIL reset_rsp got %b exp 0", {rsp_type, rsp_long, ocr_rdy}); end
    n_tests++; if (card_status !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h exp 0", card_status); end
    n_tests++; if (blk_len !== 12'd512) begin n_fail++; $display("FAIL reset_blk_len got %0d exp 512", blk_len); end
    n_tests++; if ({rd_start, wr_start, multi, bus_w4, busy, illegal_cmd} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000000", {rd_start, wr_start, multi, bus_w4, busy, illegal_cmd}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_powerup;
    logic exp_rdy;
    cmd(6'd8, 32'h0000_01AA);
    n_tests++; if (rsp_type !== 3'd7 || cur_state !== 4'd0) begin n_fail++; $display("FAIL cmd8 got rsp %0d st %0d exp 7/0", rsp_type, cur_state); end
    for (int i = 0; i < 3; i++) begin
      exp_rdy = (i == 2);
      cmd(6'd55, 32'h0);
      n_tests++; if (rsp_type !== 3'd1 || card_status[5] !== 1'b1) begin n_fail++; $display("FAIL cmd55_%0d got rsp %0d app %b exp 1/1", i, rsp_type, card_status[5]); end
      cmd(6'd41, 32'h40FF_8000);
      n_tests++; if (rsp_type !== 3'd4 || ocr_rdy !== exp_rdy || cur_state !== {3'b0, exp_rdy} || card_status[5] !== 1'b0) begin
        n_fail++; $display("FAIL acmd41_%0d got rsp %0d ocr %b st %0d exp 4/%b/%0d", i, rsp_type, ocr_rdy, cur_state, exp_rdy, exp_rdy); end
      do_rsp_end;
      n_tests++; if (rsp_type !== 3'd0) begin n_fail++; $display("FAIL rsp_clear_%0d got %0d exp 0", i, rsp_type); end
    end
    cmd(6'd2, 32'h0);
    n_tests++; if (rsp_type !== 3'd3 || rsp_long !== 1'b1 || cur_state !== 4'd2) begin
      n_fail++; $display("FAIL cmd2 got rsp %0d long %b st %0d exp 3/1/2", rsp_type, rsp_long, cur_state); end
    cmd(6'd3, 32'h0);
    n_tests++; if (rsp_type !== 3'd6 || rsp_long !== 1'b0 || rca !== 16'h0001 || cur_state !== 4'd3) begin
      n_fail++; $display("FAIL cmd3 got rsp %0d long %b rca %h st %0d exp 6/0/0001/3", rsp_type, rsp_long, rca, cur_state); end
  endtask

  task automatic test_select;
    cmd(6'd7, 32'h0001_0000);
    n_tests++; if (rsp_type !== 3'd2 || cur_state !== 4'd4 || card_status[12:8] !== 5'b01001) begin
      n_fail++; $display("FAIL cmd7_sel got rsp %0d st %0d cs %h exp 2/4/cs[12:8]=09", rsp_type, cur_state, card_status); end
    cmd(6'd16, 32'd256);
    n_tests++; if (blk_len !== 12'd256 || rsp_type !== 3'd1) begin n_fail++; $display("FAIL cmd16_256 got %0d rsp %0d exp 256/1", blk_len, rsp_type); end
    cmd(6'd16, 32'd512);
    n_tests++; if (blk_len !== 12'd512 || card_status[29] !== 1'b0) begin n_fail++; $display("FAIL cmd16_512 got %0d err %b exp 512/0", blk_len, card_status[29]); end
    cmd(6'd16, 32'd1024);
    n_tests++; if (blk_len !== 12'd512 || card_status[29] !== 1'b1 || rsp_type !== 3'd1) begin
      n_fail++; $display("FAIL cmd16_1024 got %0d err %b rsp %0d exp 512/1/1", blk_len, card_status[29], rsp_type); end
    do_rsp_end;
    n_tests++; if (card_status[29] !== 1'b0) begin n_fail++; $display("FAIL blklen_err_clear got %b exp 0", card_status[29]); end
    cmd(6'd16, 32'd0);
    n_tests++; if (blk_len !== 12'd512 || card_status[29] !== 1'b1) begin n_fail++; $display("FAIL cmd16_0 got %0d err %b exp 512/1", blk_len, card_status[29]); end
    do_rsp_end;
    cmd(6'd55, 32'h0001_0000);
    cmd(6'd6, 32'h0000_0002);
    n_tests++; if (bus_w4 !== 1'b1 || rsp_type !== 3'd1 || illegal_cmd !== 1'b0) begin
      n_fail++; $display("FAIL acmd6 got w4 %b rsp %0d ill %b exp 1/1/0", bus_w4, rsp_type, illegal_cmd); end
  endtask

  task automatic test_read;
    cmd(6'd17, 32'h0);
    n_tests++; if (rd_start !== 1'b1 || multi !== 1'b0 || cur_state !== 4'd5 || rsp_type !== 3'd1) begin
      n_fail++; $display("FAIL cmd17 got rds %b multi %b st %0d rsp %0d exp 1/0/5/1", rd_start, multi, cur_state, rsp_type); end
    @(negedge clk);
    n_tests++; if (rd_start !== 1'b0) begin n_fail++; $display("FAIL rd_start_pulse got %b exp 0", rd_start); end
    rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    n_tests++; if (cur_state !== 4'd4) begin n_fail++; $display("FAIL rd_done got st %0d exp 4", cur_state); end
  endtask

  task automatic test_write;
    int n;
    cmd(6'd25, 32'h0);
    n_tests++; if (wr_start !== 1'b1 || multi !== 1'b1 || cur_state !== 4'd6) begin
      n_fail++; $display("FAIL cmd25 got wrs %b multi %b st %0d exp 1/1/6", wr_start, multi, cur_state); end
    cmd(6'd12, 32'h0);
    n_tests++; if (cur_state !== 4'd7 || busy !== 1'b1 || rsp_type !== 3'd2) begin
      n_fail++; $display("FAIL cmd12_rcv got st %0d busy %b rsp %0d exp 7/1/2", cur_state, busy, rsp_type); end
    n = 1;
    while (cur_state == 4'd7 && n < 200) begin
      @(negedge clk);
      if (cur_state == 4'd7) n++;
    end
    n_tests++; if (n !== 64) begin n_fail++; $display("FAIL prg_cycles got %0d exp 64", n); end
    n_tests++; if (cur_state !== 4'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL prg_exit got st %0d busy %b exp 4/0", cur_state, busy); end
  endtask

  task automatic test_illegal;
    cmd(6'd2, 32'h0);
    n_tests++; if (illegal_cmd !== 1'b1 || card_status[22] !== 1'b1 || cur_state !== 4'd4 || rsp_type !== 3'd0) begin
      n_fail++; $display("FAIL illegal_cmd2 got ill %b cs22 %b st %0d rsp %0d exp 1/1/4/0", illegal_cmd, card_status[22], cur_state, rsp_type); end
    @(negedge clk);
    n_tests++; if (illegal_cmd !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b exp 0", illegal_cmd); end
    cmd(6'd13, 32'h0001_0000);
    n_tests++; if (rsp_type !== 3'd1 || card_status[22] !== 1'b1) begin
      n_fail++; $display("FAIL cmd13_report got rsp %0d cs22 %b exp 1/1", rsp_type, card_status[22]); end
    do_rsp_end;
    n_tests++; if (card_status[22] !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got %b exp 0", card_status[22]); end
  endtask

  task automatic test_priority;
    int n;
    cmd(6'd17, 32'h0);
    @(negedge clk); cmd_vld = 1'b1; cmd_idx = 6'd12; rd_done = 1'b1;
    @(negedge clk); cmd_vld = 1'b0; cmd_idx = '0; rd_done = 1'b0;
    n_tests++; if (cur_state !== 4'd4 || rsp_type !== 3'd2) begin
      n_fail++; $display("FAIL cmd12_rd_done got st %0d rsp %0d exp 4/2", cur_state, rsp_type); end
    cmd(6'd24, 32'h0);
    // CMD13 is not accepted in rcv, so the coincident wr_done still moves to prg
    @(negedge clk); cmd_vld = 1'b1; cmd_idx = 6'd13; cmd_arg = 32'h0001_0000; wr_done = 1'b1;
    @(negedge clk); cmd_vld = 1'b0; cmd_idx = '0; cmd_arg = '0; wr_done = 1'b0;
    n_tests++; if (cur_state !== 4'd7 || illegal_cmd !== 1'b1) begin
      n_fail++; $display("FAIL wr_done_ill got st %0d ill %b exp 7/1", cur_state, illegal_cmd); end
    cmd(6'd7, 32'h0);
    n_tests++; if (cur_state !== 4'd8 || busy !== 1'b1) begin n_fail++; $display("FAIL prg_to_dis got st %0d busy %b exp 8/1", cur_state, busy); end
    n = 0;
    while (cur_state == 4'd8 && n < 200) begin @(negedge clk); n++; end
    n_tests++; if (cur_state !== 4'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL dis_expiry got st %0d busy %b exp 3/0", cur_state, busy); end
    cmd(6'd7, 32'h0001_0000);
  endtask

  task automatic test_cmd0_prg;
    cmd(6'd24, 32'h0);
    @(negedge clk); wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
    n_tests++; if (cur_state !== 4'd7) begin n_fail++; $display("FAIL wr_done_prg got st %0d exp 7", cur_state); end
    cmd(6'd0, 32'h0);
    n_tests++; if (cur_state !== 4'd0 || busy !== 1'b0 || rca !== 16'h0 || bus_w4 !== 1'b0 || blk_len !== 12'd512) begin
      n_fail++; $display("FAIL cmd0_prg got st %0d busy %b rca %h w4 %b blk %0d exp 0/0/0000/0/512", cur_state, busy, rca, bus_w4, blk_len); end
  endtask

  task automatic test_ina;
    bring_to_stby;
    cmd(6'd15, 32'h0001_0000);
    n_tests++; if (cur_state !== 4'd15 || rsp_type !== 3'd0) begin n_fail++; $display("FAIL cmd15 got st %0d rsp %0d exp 15/0", cur_state, rsp_type); end
    cmd(6'd0, 32'h0);
    n_tests++; if (cur_state !== 4'd15 || illegal_cmd !== 1'b0 || rsp_type !== 3'd0) begin
      n_fail++; $display("FAIL ina_ignore got st %0d ill %b rsp %0d exp 15/0/0", cur_state, illegal_cmd, rsp_type); end
  endtask

  task automatic test_async_rst;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    bring_to_stby;
    cmd(6'd7, 32'h0001_0000);
    cmd(6'd25, 32'h0);
    @(negedge clk); wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (cur_state !== 4'd7 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst_prg got st %0d busy %b exp 7/1", cur_state, busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (cur_state !== 4'd0 || busy !== 1'b0 || rca !== 16'h0 || ocr_rdy !== 1'b0 || multi !== 1'b0 ||
                   blk_len !== 12'd512 || card_status !== 32'h0 || rsp_type !== 3'd0) begin
      n_fail++; $display("FAIL async_rst got st %0d busy %b rca %h ocr %b multi %b blk %0d cs %h rsp %0d exp all reset",
                         cur_state, busy, rca, ocr_rdy, multi, blk_len, card_status, rsp_type); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_powerup;
    test_select;
    test_read;
    test_write;
    test_illegal;
    test_priority;
    test_cmd0_prg;
    test_ina;
    test_async_rst;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_slv_card_fsm.md
Name: sd_slv_card_fsm

Overview:
- Parametrised SD-slave card state machine covering all SD card states: idle, ready, ident, stby, tran, data, rcv, prg, dis and ina.
- Accepts parsed commands from the command-line parser and tracks RCA, APP_CMD and block length.
- Emits response type, the R1 card-status word, data-path start strobes and the prg/dis busy indication.
- Sits between the slave command parser and the response/data engines.

Parameters:
- RCA_DFLT, 16'h0001: RCA published on CMD3.
- OCR_BUSY_POLLS, 2: number of ACMD41 responses reported busy before power-up completes; 0 means ready on the first ACMD41.
- PRG_CYCLES, 64: clk cycles spent in prg/dis busy; minimum 1.
- BLK_LEN_W, 12: width of block-length register.
- MAX_BLK_LEN, 512: largest legal CMD16 argument.

Ports:
- clk, input, 1: host clock.
- rst, input, 1: reset, asynchronous, active-high.
- cmd_vld, input, 1: one-cycle pulse, command parsed with good CRC.
- cmd_idx, input, 6: command index, valid with cmd_vld.
- cmd_arg, input, 32: command argument, valid with cmd_vld.
- rsp_end, input, 1: response transmission finished.
- rd_done, input, 1: read data block(s) finished.
- wr_done, input, 1: write data received.
- cur_state, output, 4: SD state code. idle=0, ready=1, ident=2, stby=3, tran=4, data=5, rcv=6, prg=7, dis=8, ina=15.
- rca, output, 16: current RCA.
- rsp_type, output, 3: response type. 0=none, 1=R1, 2=R1b, 3=R2, 4=R3, 6=R6, 7=R7.
- rsp_long, output, 1: 1 for R2 (136-bit), else 0.
- card_status, output, 32: R1 status word.
- ocr_rdy, output, 1: OCR busy bit (bit 31 of R3).
- blk_len, output, BLK_LEN_W: current block length.
- rd_start, output, 1: one-cycle pulse to start a read.
- wr_start, output, 1: one-cycle pulse to start a write.
- multi, output, 1: 1 for a multi-block transfer (CMD18/25).
- bus_w4, output, 1: 4-bit bus selected by ACMD6.
- busy, output, 1: DAT0 busy (asserted in prg and dis).
- illegal_cmd, output, 1: one-cycle pulse for a rejected command.

Behaviour:
- Reset values:
  - cur_state = idle; rca = 0; rsp_type = 0; rsp_long = 0; card_status = 0; ocr_rdy = 0; blk_len = 512.
  - rd_start, wr_start, multi, bus_w4, busy, illegal_cmd = 0.
  - Poll counter and busy counter = 0.
- Timing: a command is evaluated against cur_state in the cmd_vld cycle. State, rsp_type and strobes update on the next clk edge (latency 1). rsp_type holds until rsp_end, then clears to 0.
- "Match" means cmd_arg[31:16] == rca.
- app_cmd:
  - Set by a valid CMD55 (any state except ina, with RCA match required outside idle).
  - Cleared by the next cmd_vld.
  - ACMD41 and ACMD6 decode only while app_cmd = 1; otherwise index 41 is illegal and index 6 is illegal.
- CMD0 in any state except ina: go to idle. Clear rca, app_cmd, bus_w4, ocr_rdy and the poll counter; blk_len = 512; rsp_type = none.
- idle:
  - CMD8 -> R7, stay.
  - ACMD41 while poll count < OCR_BUSY_POLLS -> R3 with ocr_rdy = 0, increment count, stay.
  - ACMD41 otherwise -> R3 with ocr_rdy = 1, go to ready.
- ready: CMD2 -> R2, go to ident.
- ident: CMD3 -> rca = RCA_DFLT, R6, go to stby.
- stby:
  - CMD3 -> R6 (rca unchanged), stay.
  - CMD9 or CMD10 with match -> R2, stay.
  - CMD7 with match -> R1b, go to tran.
  - CMD13 with match -> R1, stay.
  - CMD15 with match -> go to ina (no response).
- tran:
  - CMD16 with arg <= MAX_BLK_LEN and arg != 0 -> blk_len = arg, R1.
  - CMD16 otherwise -> BLOCK_LEN_ERROR (bit 29), R1, blk_len unchanged.
  - CMD17 or CMD18 -> R1, rd_start, go to data. multi = (idx == 18).
  - CMD24 or CMD25 -> R1, wr_start, go to rcv. multi = (idx == 25).
  - ACMD6 -> bus_w4 = (arg[1:0] == 2'b10), R1.
  - CMD13 -> R1.
  - CMD7 without match -> go to stby (no response).
- data:
  - CMD12 -> R1b, go to tran.
  - rd_done with multi = 0 -> go to tran.
  - CMD7 without match -> go to stby.
- rcv:
  - wr_done -> go to prg.
  - CMD12 -> R1b, go to prg.
- prg:
  - busy = 1; busy counter runs for PRG_CYCLES, then go to tran.
  - CMD7 without match -> go to dis (counter continues).
  - CMD13 -> R1.
- dis:
  - busy counter expiry -> go to stby.
  - CMD7 with match -> go to prg.
- ina: all commands ignored (no response, no illegal pulse). Exit only by rst.
- Illegal commands: any index not listed for the current state gives no state change, rsp_type = none, an illegal_cmd pulse, and sets sticky ILLEGAL_COMMAND (bit 22).
- card_status:
  - Bits [12:9] = cur_state.
  - Bit 8 READY_FOR_DATA = (state == tran).
  - Bit 5 = app_cmd.
  - Bits 22 and 29 are sticky and clear on rsp_end of the next R1/R1b; if a set and a clear occur in the same cycle, the set wins.
- Simultaneous events:
  - If cmd_vld and rd_done/wr_done/busy expiry occur together, the command transition takes priority and the data event is dropped only if the command changed state.
  - Otherwise the data event applies in the same edge.
- An asynchronous rst mid-transfer returns every output to its reset value immediately.

Decomposition:
- Package sd_slv_pkg: state encodings, command index constants, rsp_type encodings, card_status bit positions.
- Sub-module sd_slv_cmd_dec: combinational legality and response-type table. Inputs are state, idx, app_cmd and match; outputs are legal, rsp_type and next-state request.

Test Plan:
- Power-up with OCR_BUSY_POLLS = 2:
  - CMD55, ACMD41 twice -> R3 with ocr_rdy = 0, state stays 0.
  - Third pair -> ocr_rdy = 1, state = 1.
  - CMD2 -> R2, rsp_long = 1, state = 2.
  - CMD3 -> R6, rca = 16'h0001, state = 3.
- Select and block length:
  - CMD7 arg = 32'h0001_0000 -> R1b, state = 4.
  - CMD16 arg = 512 -> blk_len = 512.
  - CMD16 arg = 1024 -> card_status[29] = 1, cleared after rsp_end.
- Single read: CMD17 -> rd_start pulse, state = 5; rd_done -> state = 4.
- Write: CMD25 -> wr_start, multi = 1, state = 6. CMD12 -> state = 7, busy = 1 for 64 cycles, then state = 4.
- Illegal command: CMD2 in tran -> illegal_cmd pulse, card_status[22] = 1, state stays 4. Next CMD13 response rsp_end clears bit 22.
- Reset and priority:
  - CMD0 in prg -> state = 0, busy = 0, rca = 0.
  - CMD12 coincident with rd_done in data -> single transition to tran.
  - rst asserted mid-prg -> all outputs reset asynchronously.
